wb_user_bus_ctrl: RTL and testbench

- Wishbone interconnect controller for the user project area. Shares one user-side Wishbone bus between two requesters:
  - m0: management SoC Wishbone (wbs_* from the wrapper).
  - m1: LA-driven debug master.
- Round-robin arbitration, address decode to two slaves (user core "user", debug register window "dbg"), single registered response path, bus-timeout watchdog.
- Replaces the ad-hoc combinational cyc/ack/dat splitting in the wrapper. Lives directly inside user_project_wrapper.

---
 rtl/wb_user_bus_ctrl.sv | 156 +++++++++++++++
 tb/tb_wb_user_bus_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_user_bus_ctrl.sv
// Shares the user-area Wishbone bus between the management SoC and an LA debug master.
// Round-robin grant, two-slave decode, one registered response, bus watchdog.
module wb_user_bus_ctrl #(
   parameter logic [28:0] DBG_TAG  = 29'h601FFFF,
   parameter int unsigned TIMEOUT  = 255,
   parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        m0_cyc_i,
   input  logic        m0_stb_i,
   input  logic        m0_we_i,
   input  logic [3:0]  m0_sel_i,
   input  logic [31:0] m0_adr_i,
   input  logic [31:0] m0_dat_i,
   output logic        m0_ack_o,
   output logic [31:0] m0_dat_o,
   input  logic        m1_cyc_i,
   input  logic        m1_stb_i,
   input  logic        m1_we_i,
   input  logic [3:0]  m1_sel_i,
   input  logic [31:0] m1_adr_i,
   input  logic [31:0] m1_dat_i,
   output logic        m1_ack_o,
   output logic [31:0] m1_dat_o,
   output logic        s_we_o,
   output logic [3:0]  s_sel_o,
   output logic [31:0] s_adr_o,
   output logic [31:0] s_dat_o,
   output logic        s_stb_o,
   output logic        user_cyc_o,
   input  logic        user_ack_i,
   input  logic [31:0] user_dat_i,
   output logic        dbg_cyc_o,
   input  logic        dbg_ack_i,
   input  logic [31:0] dbg_dat_i,
   output logic        timeout_o,
   output logic [7:0]  err_count_o
);

   typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;

   localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

   state_e      state_q, state_d;
   logic        grant_q, grant_d;
   logic        last_q, last_d;
   logic        dbg_q, dbg_d;
   logic [15:0] wdog_q, wdog_d;
   logic [31:0] rdata_q, rdata_d;
   logic [7:0]  errcnt_q, errcnt_d;
   logic        tout_q, tout_d;

   logic        m0_req, m1_req;
   logic        g_cyc, g_we;
   logic [3:0]  g_sel;
   logic [31:0] g_adr, g_dat;
   logic        s_ack;
   logic [31:0] s_rdat;
   logic        bus, act, resp;

   assign m0_req = m0_cyc_i & m0_stb_i;
   assign m1_req = m1_cyc_i & m1_stb_i;

   assign g_cyc  = grant_q ? m1_cyc_i : m0_cyc_i;
   assign g_we   = grant_q ? m1_we_i  : m0_we_i;
   assign g_sel  = grant_q ? m1_sel_i : m0_sel_i;
   assign g_adr  = grant_q ? m1_adr_i : m0_adr_i;
   assign g_dat  = grant_q ? m1_dat_i : m0_dat_i;
   assign s_ack  = dbg_q ? dbg_ack_i : user_ack_i;
   assign s_rdat = dbg_q ? dbg_dat_i : user_dat_i;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q  <= IDLE;
         grant_q  <= 1'b0;
         last_q   <= 1'b1;
         dbg_q    <= 1'b0;
         wdog_q   <= '0;
         rdata_q  <= '0;
         errcnt_q <= '0;
         tout_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         last_q   <= last_d;
         dbg_q    <= dbg_d;
         wdog_q   <= wdog_d;
         rdata_q  <= rdata_d;
         errcnt_q <= errcnt_d;
         tout_q   <= tout_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      last_d   = last_q;
      dbg_d    = dbg_q;
      wdog_d   = wdog_q;
      rdata_d  = rdata_q;
      errcnt_d = errcnt_q;
      tout_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            wdog_d = '0;
            if (m0_req | m1_req) begin
               // On a tie the master that did not win last time goes first
               grant_d = (m0_req & m1_req) ? ~last_q : m1_req;
               last_d  = grant_d;
               dbg_d   = (grant_d ? m1_adr_i[31:3] : m0_adr_i[31:3]) == DBG_TAG;
               state_d = BUS;
            end
         end
         BUS: begin
            wdog_d = wdog_q + 16'd1;
            if (!g_cyc) begin
               state_d = IDLE;
            end else if (s_ack) begin
               rdata_d = s_rdat;
               state_d = RESP;
            end else if (wdog_q == WD_LAST) begin
               rdata_d = ERR_DATA;
               tout_d  = 1'b1;
               if (errcnt_q != 8'hFF) errcnt_d = errcnt_q + 8'd1;
               state_d = RESP;
            end
         end
         RESP: begin
            wdog_d  = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus  = state_q == BUS;
   assign act  = bus & g_cyc;
   assign resp = state_q == RESP;

   assign s_stb_o    = act;
   assign s_we_o     = bus & g_we;
   assign s_sel_o    = bus ? g_sel : '0;
   assign s_adr_o    = bus ? g_adr : '0;
   assign s_dat_o    = bus ? g_dat : '0;
   assign user_cyc_o = act & ~dbg_q;
   assign dbg_cyc_o  = act & dbg_q;

   assign m0_ack_o    = resp & ~grant_q;
   assign m1_ack_o    = resp & grant_q;
   assign m0_dat_o    = m0_ack_o ? rdata_q : '0;
   assign m1_dat_o    = m1_ack_o ? rdata_q : '0;
   assign timeout_o   = tout_q;
   assign err_count_o = errcnt_q;

endmodule

// File: tb/tb_wb_user_bus_ctrl.sv
// Directed bench for wb_user_bus_ctrl: transfers, round-robin,
// watchdog, abort and reset, with behavioural slaves.
module tb_wb_user_bus_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
   logic [3:0]  m0_sel, m1_sel;
   logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat;
   logic        m0_ack, m1_ack;
   logic [31:0] m0_rd, m1_rd;
   logic        s_we, s_stb, user_cyc, dbg_cyc, user_ack, dbg_ack, tmo;
   logic [3:0]  s_sel;
   logic [31:0] s_adr, s_dat, user_dat, dbg_dat;
   logic [7:0]  errc;

   logic u_en, d_en;
   int   u_lat, d_lat, ucnt, dcnt;
   int   n_vec = 0, n_bad = 0;

   always #5 clk = ~clk;

   wb_user_bus_ctrl dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we),
      .m0_sel_i(m0_sel), .m0_adr_i(m0_adr), .m0_dat_i(m0_dat),
      .m0_ack_o(m0_ack), .m0_dat_o(m0_rd),
      .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we),
      .m1_sel_i(m1_sel), .m1_adr_i(m1_adr), .m1_dat_i(m1_dat),
      .m1_ack_o(m1_ack), .m1_dat_o(m1_rd),
      .s_we_o(s_we), .s_sel_o(s_sel), .s_adr_o(s_adr), .s_dat_o(s_dat),
      .s_stb_o(s_stb),
      .user_cyc_o(user_cyc), .user_ack_i(user_ack), .user_dat_i(user_dat),
      .dbg_cyc_o(dbg_cyc), .dbg_ack_i(dbg_ack), .dbg_dat_i(dbg_dat),
      .timeout_o(tmo), .err_count_o(errc)
   );

   // Slaves ack after a programmable number of cycles of cyc
   always @(posedge clk) begin
      ucnt <= user_cyc ? ucnt + 1 : 0;
      dcnt <= dbg_cyc ? dcnt + 1 : 0;
   end
   assign user_ack = u_en & user_cyc & (ucnt == u_lat);
   assign dbg_ack  = d_en & dbg_cyc & (dcnt == d_lat);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc1();
      @(posedge clk);
      @(negedge clk);
   endtask

   int ack_at, pulses, acks;

   initial begin
      rst = 1'b1;
      {m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we} = '0;
      m0_sel = 4'hF; m1_sel = 4'hF;
      m0_adr = '0; m0_dat = '0; m1_adr = '0; m1_dat = '0;
      user_dat = 32'h0BADF00D; dbg_dat = 32'hA5A5A5A5;
      u_en = 1'b1; d_en = 1'b1; u_lat = 0; d_lat = 0;
      ucnt = 0; dcnt = 0;
      repeat (3) cyc1();
      chk("rst_ucyc", 32'(user_cyc), 0);
      chk("rst_dcyc", 32'(dbg_cyc), 0);
      chk("rst_stb", 32'(s_stb), 0);
      chk("rst_adr", s_adr, 0);
      chk("rst_ack", 32'({m0_ack, m1_ack}), 0);
      chk("rst_err", 32'(errc), 0);
      chk("rst_tmo", 32'(tmo), 0);
      rst = 1'b0;
      cyc1();

      // m0 write to user, slave acks 2 cycles after cyc
      u_lat = 2;
      m0_adr = 32'h30000004; m0_dat = 32'h12345678; m0_we = 1'b1;
      m0_cyc = 1'b1; m0_stb = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         cyc1();
         chk($sformatf("t1_ucyc%0d", c), 32'(user_cyc), 32'(c <= 3));
         chk($sformatf("t1_dcyc%0d", c), 32'(dbg_cyc), 0);
         chk($sformatf("t1_ack%0d", c), 32'(m0_ack), 32'(c == 4));
         if (c <= 3) begin
            chk("t1_adr", s_adr, 32'h30000004);
            chk("t1_dat", s_dat, 32'h12345678);
            chk("t1_rd0", m0_rd, 0);
         end
      end
      {m0_cyc, m0_stb, m0_we} = '0;
      cyc1();

      // m1 read from dbg window, same-cycle ack
      m1_adr = 32'h300FFFFC; m1_cyc = 1'b1; m1_stb = 1'b1;
      cyc1();
      chk("t2_dcyc", 32'(dbg_cyc), 1);
      chk("t2_ucyc", 32'(user_cyc), 0);
      chk("t2_ack1", 32'(m1_ack), 0);
      cyc1();
      chk("t2_ack", 32'(m1_ack), 1);
      chk("t2_rd", m1_rd, 32'hA5A5A5A5);
      chk("t2_m0ack", 32'(m0_ack), 0);
      chk("t2_m0rd", m0_rd, 0);
      chk("t2_ucyc2", 32'(user_cyc), 0);
      {m1_cyc, m1_stb} = '0;
      cyc1();

      // Both masters streaming to user, immediate acks
      u_lat = 0;
      m0_adr = 32'h30000100; m1_adr = 32'h30000200;
      {m0_cyc, m0_stb, m1_cyc, m1_stb} = 4'hF;
      for (int c = 1; c <= 12; c++) begin
         cyc1();
         chk($sformatf("t3_m0ack%0d", c), 32'(m0_ack), 32'(c % 6 == 2));
         chk($sformatf("t3_m1ack%0d", c), 32'(m1_ack), 32'(c % 6 == 5));
      end
      {m0_cyc, m0_stb, m1_cyc, m1_stb} = '0;
      cyc1();

      // Watchdog: no ack from user
      u_en = 1'b0;
      m0_adr = 32'h30000010;
      {m0_cyc, m0_stb} = 2'b11;
      ack_at = 0; pulses = 0;
      for (int c = 1; c <= 256; c++) begin
         cyc1();
         if (m0_ack && ack_at == 0) ack_at = c;
         if (tmo) pulses++;
      end
      chk("t4_lat", ack_at, 256);
      chk("t4_rd", m0_rd, 32'hDEADBEEF);
      chk("t4_err", 32'(errc), 1);
      {m0_cyc, m0_stb} = '0;
      cyc1();
      chk("t4_pulses", pulses, 1);
      chk("t4_tmo_low", 32'(tmo), 0);

      // Hold m0 requesting until the error count saturates
      {m0_cyc, m0_stb} = 2'b11;
      acks = 0;
      for (int i = 0; i < 68000 && acks < 260; i++) begin
         cyc1();
         if (m0_ack) begin
            acks++;
            if (acks == 253) chk("t4_err254", 32'(errc), 254);
         end
      end
      chk("t4_nacks", acks, 260);
      chk("t4_sat", 32'(errc), 255);
      {m0_cyc, m0_stb} = '0;
      cyc1();

      // m1 aborts 3 cycles into BUS while m0 waits
      m0_adr = 32'h30000020; m1_adr = 32'h30000040;
      {m0_cyc, m0_stb, m1_cyc, m1_stb} = 4'hF;
      for (int c = 1; c <= 3; c++) begin
         cyc1();
         chk($sformatf("t5_ucyc%0d", c), 32'(user_cyc), 1);
         chk($sformatf("t5_adr%0d", c), s_adr, 32'h30000040);
      end
      {m1_cyc, m1_stb} = '0;
      cyc1();
      chk("t5_ucyc_drop", 32'(user_cyc), 0);
      chk("t5_stb_drop", 32'(s_stb), 0);
      chk("t5_m1ack", 32'(m1_ack), 0);
      u_en = 1'b1;
      cyc1();
      chk("t5_m0_bus", 32'(user_cyc), 1);
      chk("t5_m0_adr", s_adr, 32'h30000020);
      cyc1();
      chk("t5_m0ack", 32'(m0_ack), 1);
      chk("t5_m1ack2", 32'(m1_ack), 0);
      {m0_cyc, m0_stb} = '0;
      cyc1();

      // Reset during BUS drops the transfer
      u_en = 1'b0;
      {m1_cyc, m1_stb} = 2'b11;
      cyc1();
      chk("t6_bus", 32'(user_cyc), 1);
      rst = 1'b1;
      cyc1();
      rst = 1'b0;
      {m1_cyc, m1_stb} = '0;
      chk("t6_ucyc", 32'(user_cyc), 0);
      chk("t6_stb", 32'(s_stb), 0);
      chk("t6_ack", 32'({m0_ack, m1_ack}), 0);
      chk("t6_err", 32'(errc), 0);
      cyc1();
      chk("t6_noack", 32'(m1_ack), 0);
      u_en = 1'b1;
      {m0_cyc, m0_stb, m1_cyc, m1_stb} = 4'hF;
      cyc1();
      chk("t6_tie_adr", s_adr, 32'h30000020);
      cyc1();
      chk("t6_tie_ack", 32'(m0_ack), 1);
      {m0_cyc, m0_stb, m1_cyc, m1_stb} = '0;
      cyc1();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
